// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one synchronous memory port between the CPU
// and a host loader/debug port using an IDLE -> ACCESS -> CAPTURE sequence.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned MEM_ADDR_SIZE = 16,
  parameter int unsigned CPU_PRIORITY  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]     cpu_wdata,
  output logic                     cpu_ready,
  output logic [WORD_SIZE-1:0]     cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [MEM_ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0]     host_wdata,
  output logic                     host_ready,
  output logic [WORD_SIZE-1:0]     host_rdata,
  input  logic                     host_lock,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_read_data,
  output logic                     busy,
  output logic                     owner
);

  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic                     we;
    logic [MEM_ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0]     wdata;
  } access_t;

  state_t              state_q, state_d;
  access_t             acc_q, acc_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [WORD_SIZE-1:0] cpu_rdata_q, host_rdata_q;
  logic                cpu_elig;
  logic                host_wins;

  // State, grant and latched request registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      owner_q      <= OWNER_CPU;
      last_owner_q <= OWNER_HOST;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if (cpu_ready && !acc_q.we) begin
        cpu_rdata_q <= mem_read_data;
      end
      if (host_ready && !acc_q.we) begin
        host_rdata_q <= mem_read_data;
      end
    end
  end

  // Arbitration and next-state; on a tie without CPU priority the last owner yields
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cpu_elig     = cpu_req && !host_lock;
    host_wins    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_elig || host_req) begin
          if (cpu_elig && host_req) begin
            host_wins = (CPU_PRIORITY == 32'd0) && (last_owner_q == OWNER_CPU);
          end else begin
            host_wins = host_req;
          end
          owner_d      = host_wins;
          last_owner_d = host_wins;
          if (host_wins) begin
            acc_d = '{we: host_we, addr: host_addr, wdata: host_wdata};
          end else begin
            acc_d = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          end
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and ready are state decodes, suppressed while reset is high
  assign mem_read       = (state_q == ACCESS) && !acc_q.we && !reset;
  assign mem_write      = (state_q == ACCESS) && acc_q.we && !reset;
  assign cpu_ready      = (state_q == CAPTURE) && (owner_q == OWNER_CPU) && !reset;
  assign host_ready     = (state_q == CAPTURE) && (owner_q == OWNER_HOST) && !reset;
  assign cpu_rdata      = (cpu_ready && !acc_q.we) ? mem_read_data : cpu_rdata_q;
  assign host_rdata     = (host_ready && !acc_q.we) ? mem_read_data : host_rdata_q;
  assign cpu_stall      = cpu_req && !cpu_ready;
  assign mem_address    = acc_q.addr;
  assign mem_write_data = acc_q.wdata;
  assign busy           = (state_q != IDLE);
  assign owner          = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a synchronous memory model.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ready, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_ready, host_lock;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, busy, owner;

  mem_arbiter #(.WORD_SIZE(16), .MEM_ADDR_SIZE(16), .CPU_PRIORITY(0)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rdata(host_rdata), .host_lock(host_lock),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    bit          host;
    bit          we;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] mem[256];
  logic [15:0] exp_mem[256];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: read data valid the cycle after the strobe
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 16'hBEEF : 16'h5A00 + 16'(i);
    end else begin
      if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
      if (mem_read) mem_read_data <= mem[mem_address[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every completion is matched against the next scoreboard entry
  always @(negedge clock) begin
    if (!reset && (cpu_ready || host_ready)) begin
      check("one_ready", 32'(cpu_ready && host_ready), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ready_port", 32'(host_ready), 32'(mon_e.host));
        if (!mon_e.we) check("rdata", 32'(mon_e.host ? host_rdata : cpu_rdata), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input bit host, input bit we, input logic [15:0] addr);
    exp_t e;
    e.host = host;
    e.we   = we;
    e.data = exp_mem[addr[7:0]];
    sb.push_back(e);
  endtask

  task automatic cpu_drive(input bit we, input logic [15:0] addr, input logic [15:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic host_drive(input bit we, input logic [15:0] addr, input logic [15:0] wd);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
  endtask

  task automatic wait_ready(input bit host);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = host ? host_ready : cpu_ready;
    end
    if (!seen) check(host ? "host_ready_timeout" : "cpu_ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    if (host) host_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int rc[4];
    for (int i = 0; i < 256; i++) exp_mem[i] = (i == 4) ? 16'hBEEF : 16'h5A00 + 16'(i);
    reset = 1'b1; host_lock = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (2) tick();

    // Reset state
    @(negedge clock);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);

    // CPU read of address 4
    tick();
    push(1'b0, 1'b0, 16'h0004);
    cpu_drive(1'b0, 16'h0004, 16'h0000);
    @(negedge clock);
    check("rd_idle_busy", 32'(busy), 32'd0);
    check("rd_stall", 32'(cpu_stall), 32'd1);
    tick(); @(negedge clock);
    check("rd_strobe", 32'(mem_read), 32'd1);
    check("rd_addr", 32'(mem_address), 32'h0004);
    check("rd_no_write", 32'(mem_write), 32'd0);
    tick(); @(negedge clock);
    check("rd_ready", 32'(cpu_ready), 32'd1);
    tick(); cpu_req = 1'b0;
    @(negedge clock);
    check("rd_hold", 32'(cpu_rdata), 32'hBEEF);
    check("rd_ready_pulse", 32'(cpu_ready), 32'd0);

    // Host write then CPU read-back
    tick();
    exp_mem[16] = 16'h1234;
    push(1'b1, 1'b1, 16'h0010);
    host_drive(1'b1, 16'h0010, 16'h1234);
    tick(); @(negedge clock);
    check("wr_strobe", 32'(mem_write), 32'd1);
    check("wr_no_read", 32'(mem_read), 32'd0);
    check("wr_addr", 32'(mem_address), 32'h0010);
    check("wr_data", 32'(mem_write_data), 32'h1234);
    check("wr_owner", 32'(owner), 32'd1);
    tick(); @(negedge clock);
    check("wr_ready", 32'(host_ready), 32'd1);
    tick(); host_req = 1'b0;
    @(negedge clock);
    check("wr_rdata_kept", 32'(host_rdata), 32'd0);
    tick();
    push(1'b0, 1'b0, 16'h0010);
    cpu_drive(1'b0, 16'h0010, 16'h0000);
    wait_ready(1'b0);
    push(1'b1, 1'b0, 16'h0020);
    host_drive(1'b0, 16'h0020, 16'h0000);
    wait_ready(1'b1);

    // Contention: strict alternation starting with the CPU
    push(1'b0, 1'b0, 16'h0001); push(1'b1, 1'b0, 16'h0002);
    push(1'b0, 1'b0, 16'h0001); push(1'b1, 1'b0, 16'h0002);
    cpu_drive(1'b0, 16'h0001, 16'h0000);
    host_drive(1'b0, 16'h0002, 16'h0000);
    got = 0;
    for (int i = 0; i < 4; i++) rc[i] = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      @(negedge clock);
      if (cpu_ready || host_ready) begin rc[got] = cyc; got++; end
    end
    check("rr_count", 32'(got), 32'd4);
    @(posedge clock); #1; cpu_req = 1'b0; host_req = 1'b0;
    for (int i = 1; i < 4; i++) check("rr_spacing", 32'(rc[i] - rc[i-1]), 32'd3);
    @(negedge clock);
    check("rr_host_rdata", 32'(host_rdata), 32'h5A02);

    // Host lock keeps the CPU out
    tick();
    host_lock = 1'b1;
    push(1'b1, 1'b0, 16'h0005); push(1'b1, 1'b0, 16'h0005); push(1'b1, 1'b0, 16'h0005);
    cpu_drive(1'b0, 16'h0003, 16'h0000);
    host_drive(1'b0, 16'h0005, 16'h0000);
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      @(negedge clock);
      check("lock_stall", 32'(cpu_stall), 32'd1);
      check("lock_cpu_ready", 32'(cpu_ready), 32'd0);
      if (host_ready) got++;
    end
    check("lock_count", 32'(got), 32'd3);
    @(posedge clock); #1; host_req = 1'b0; host_lock = 1'b0;
    push(1'b0, 1'b0, 16'h0003);
    @(negedge clock);
    check("unlock_idle", 32'(busy), 32'd0);
    tick(); @(negedge clock);
    check("unlock_owner", 32'(owner), 32'd0);
    check("unlock_strobe", 32'(mem_read), 32'd1);
    check("unlock_addr", 32'(mem_address), 32'h0003);
    tick(); @(negedge clock);
    check("unlock_ready", 32'(cpu_ready), 32'd1);
    tick(); cpu_req = 1'b0;

    // Reset during ACCESS
    cpu_drive(1'b0, 16'h0006, 16'h0000);
    tick(); reset = 1'b1;
    @(negedge clock);
    check("rsta_strobe", 32'(mem_read), 32'd0);
    check("rsta_ready", 32'(cpu_ready), 32'd0);
    tick(); reset = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    check("rsta_idle", 32'(busy), 32'd0);
    check("rsta_ready2", 32'(cpu_ready), 32'd0);
    check("rsta_rdata", 32'(cpu_rdata), 32'd0);
    check("rsta_host_rdata", 32'(host_rdata), 32'd0);

    // Reset during CAPTURE
    tick();
    cpu_drive(1'b0, 16'h0007, 16'h0000);
    tick(); tick(); reset = 1'b1;
    @(negedge clock);
    check("rstc_ready", 32'(cpu_ready), 32'd0);
    check("rstc_strobe", 32'(mem_read), 32'd0);
    tick(); reset = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    check("rstc_idle", 32'(busy), 32'd0);
    check("rstc_ready2", 32'(cpu_ready), 32'd0);
    check("rstc_rdata", 32'(cpu_rdata), 32'd0);

    // Requester address changes after grant are ignored
    tick();
    push(1'b0, 1'b0, 16'h0004);
    cpu_drive(1'b0, 16'h0004, 16'h0000);
    tick(); cpu_addr = 16'h0008;
    @(negedge clock);
    check("late_addr", 32'(mem_address), 32'h0004);
    wait_ready(1'b0);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single synchronous memory port between the CPU (instruction fetch and LOAD/STORE traffic) and a host loader/debug port. Each requester issues a held request and receives a one-cycle ready pulse on completion. A small FSM sequences every access through arbitrate, strobe and capture phases. The block sits between the `cpu` memory interface, the host port and the memory array.

## Interface
- `WORD_SIZE`, 16, data width in bits.
- `MEM_ADDR_SIZE`, 16, address width in bits.
- `CPU_PRIORITY`, 0: 0 gives round-robin on conflict; 1 gives the CPU fixed priority.

Clocking: one clock; reset is synchronous and active-high.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  MEM_ADDR_SIZE  CPU address.
- `cpu_wdata`  in  WORD_SIZE  CPU write data.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  WORD_SIZE  CPU read data.
- `cpu_stall`  out  1  `cpu_req && !cpu_ready`; gates the CPU control FSM.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ready`, `host_rdata`: host port, same meaning and widths as the CPU set.
- `host_lock`  in  1  while high, the CPU is never granted.
- `mem_address`  out  MEM_ADDR_SIZE  memory address.
- `mem_write_data`  out  WORD_SIZE  memory write data.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_read_data`  in  WORD_SIZE  memory read data, valid one cycle after `mem_read`.
- `busy`  out  1  state is not IDLE.
- `owner`  out  1  latched grant owner: 0 = CPU, 1 = HOST (debug).

## Operation

FSM states: IDLE → ACCESS → CAPTURE → IDLE.

**IDLE**
- Eligible requesters: `cpu_req && !host_lock`, and `host_req`.
- None eligible: stay in IDLE.
- Exactly one eligible: that requester wins.
- Both eligible:
  - `CPU_PRIORITY=1`: CPU wins.
  - `CPU_PRIORITY=0`: the requester that is not `last_owner` wins.
- On grant, latch `owner`, `we`, `addr` and `wdata` from the winner, set `last_owner` to the winner, and go to ACCESS.

**ACCESS**
- `mem_read = !we_q` and `mem_write = we_q` for exactly one cycle.
- Address and data come from the latched values; requester inputs are ignored after the grant.
- Always go to CAPTURE.

**CAPTURE**
- Assert the owner's `*_ready`.
- For reads, the owner's `*_rdata` passes `mem_read_data` straight through. The owner's `rdata_q` register loads `mem_read_data` at the end of the cycle.
- Writes leave `rdata_q` unchanged.
- Always go to IDLE.

**Outputs outside these windows**
- `*_rdata` outputs show their `rdata_q` registers.
- `mem_read` and `mem_write` are 0.
- `mem_address` and `mem_write_data` show the latched values.

**Requester rule**
- A requester deasserts `req` or presents a new request on the edge where it sees `ready`.
- A `req` still high in the next IDLE cycle is a new access.

**Other rules**
- `host_lock` is sampled only in IDLE. An in-flight CPU access completes normally.
- The non-owner's `ready` is 0 at all times while the other port is being served.

## Timing

Reset values:
- state = IDLE, `last_owner` = HOST (the CPU wins the first tie), `owner` = 0.
- `rdata_q` (both ports) = 0, latched `addr`/`wdata`/`we` = 0.
- All ready and strobe outputs = 0.

Latency and throughput:
- A request seen in IDLE at cycle N gives the strobe in cycle N+1 and `ready` in cycle N+2.
- Minimum access time is 3 cycles; back-to-back throughput is one access per 3 cycles.
- Read data is valid in the same cycle as `ready` and holds until that port's next read completes.

Boundary conditions:
- Reset asserted in any state forces IDLE on the next edge. `mem_read`, `mem_write`, `cpu_ready` and `host_ready` are forced to 0 during any cycle in which `reset` is high. No pending ready is delivered after reset.
- Simultaneous requests with `CPU_PRIORITY=0` alternate grants strictly. Neither port waits more than one foreign access.
- Widths are passed through unmodified. No address arithmetic; no wrap handling is needed.

## Test plan
- **Reset** → all outputs 0 and `busy=0`. `cpu_req=1`, `cpu_we=0`, `cpu_addr=0x0004`, memory[4]=0xBEEF → `mem_read` in cycle 1, `cpu_ready=1` with `cpu_rdata=0xBEEF` in cycle 2, `cpu_rdata` still 0xBEEF after `req` drops.
- **Host write:** `host_we=1`, `addr=0x0010`, `wdata=0x1234` → `mem_write=1` for one cycle with those values, `host_ready` one cycle later. A following CPU read of 0x0010 returns 0x1234.
- **Contention, `CPU_PRIORITY=0`:** both ports hold read requests for 4 accesses → owner order CPU, HOST, CPU, HOST; each `ready` lands only on its owner; one access every 3 cycles.
- **Host lock:** `host_lock=1` with both requesting for 3 accesses → only the host is granted. `cpu_stall=1` throughout; the CPU is granted on the first IDLE after `host_lock` drops.
- **Reset mid-access:** `reset` pulsed in ACCESS, then in CAPTURE → no ready pulse, strobes 0, state IDLE next cycle, `rdata_q` cleared to 0.
- **Input change after grant:** change `cpu_addr` from 0x0004 to 0x0008 in ACCESS → the memory still sees 0x0004; the returned data is from address 4.
